line_mem_responder: RTL and testbench



---
 rtl/line_mem_pkg.sv | 28 ++
 rtl/line_mem_array.sv | 33 +++
 rtl/line_mem_responder.sv | 121 ++++++++++++
 tb/tb_line_mem_responder.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/line_mem_pkg.sv
// Shared definitions for the line-granular backing memory and its clients:
// FSM/op encodings plus default geometry and latency.
package line_mem_pkg;

  localparam int LM_CACHE_LINE_WIDTH = 128;
  localparam int LM_ADDR_WIDTH       = 32;
  localparam int LM_DATA_WIDTH       = 32;
  localparam int LM_BLOCK_SIZE       = 4;
  localparam int LM_MEM_DEPTH        = 256;
  localparam int LM_LATENCY          = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } lm_state_t;

  typedef enum logic {
    OP_RD,
    OP_WR
  } lm_op_t;

  // Width needed to hold values 0..n-1, never less than one bit.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/line_mem_array.sv
// Line storage: one synchronous write port, combinational read, and a
// synchronous clear of every line while rst is high.
module line_mem_array
  import line_mem_pkg::*;
#(
  parameter int LINE_W = LM_CACHE_LINE_WIDTH,
  parameter int DEPTH  = LM_MEM_DEPTH,
  parameter int IDX_W  = clog2_min1(LM_MEM_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [LINE_W-1:0] wr_line,
  output logic [LINE_W-1:0] rd_line
);

  logic [LINE_W-1:0] mem [DEPTH];

  // Reset wins over a coincident write, so an aborted write never lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[idx] <= wr_line;
    end
  end

  assign rd_line = mem[idx];

endmodule

// File: rtl/line_mem_responder.sv
// Memory-side responder for cache refill / write-back: one line access at a
// time, fixed LATENCY wait, one-cycle mem_ready pulse on completion.
module line_mem_responder
  import line_mem_pkg::*;
#(
  parameter int CACHE_LINE_WIDTH = LM_CACHE_LINE_WIDTH,
  parameter int ADDR_WIDTH       = LM_ADDR_WIDTH,
  parameter int DATA_WIDTH       = LM_DATA_WIDTH,
  parameter int BLOCK_SIZE       = LM_BLOCK_SIZE,
  parameter int MEM_DEPTH        = LM_MEM_DEPTH,
  parameter int LATENCY          = LM_LATENCY
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        mem_rd_req,
  input  logic                        mem_wr_req,
  input  logic [ADDR_WIDTH-1:0]       mem_addr,
  input  logic [CACHE_LINE_WIDTH-1:0] mem_wr_data,
  output logic [CACHE_LINE_WIDTH-1:0] mem_rd_data,
  output logic                        mem_ready,
  output logic                        mem_busy
);

  localparam int WSEL_W = clog2_min1(BLOCK_SIZE);
  localparam int LA_W   = ADDR_WIDTH - WSEL_W;
  localparam int IDX_W  = clog2_min1(MEM_DEPTH);
  localparam int CNT_W  = clog2_min1(LATENCY);

  if (CACHE_LINE_WIDTH != DATA_WIDTH * BLOCK_SIZE) begin : g_bad_line_width
    $error("line_mem_responder: CACHE_LINE_WIDTH must equal DATA_WIDTH*BLOCK_SIZE");
  end
  if (LATENCY < 1) begin : g_bad_latency
    $error("line_mem_responder: LATENCY must be at least 1");
  end

  lm_state_t state, state_next;
  lm_op_t    op_q;

  logic [CNT_W-1:0]            cnt_q, cnt_next;
  logic [IDX_W-1:0]            idx_q, req_idx;
  logic [LA_W-1:0]             line_addr;
  logic [CACHE_LINE_WIDTH-1:0] wr_line_q, rd_line_q, arr_rd_line;
  logic                        capture, load_rd, commit_wr;
  logic                        unused_word_sel;

  // Word-in-line bits select nothing here; the whole line always moves.
  assign unused_word_sel = ^mem_addr[WSEL_W-1:0];
  assign line_addr       = mem_addr[ADDR_WIDTH-1:WSEL_W];
  assign req_idx         = IDX_W'(line_addr % LA_W'(MEM_DEPTH));

  always_comb begin
    state_next = state;
    cnt_next   = cnt_q;
    capture    = 1'b0;
    load_rd    = 1'b0;
    commit_wr  = 1'b0;
    case (state)
      IDLE: begin
        if (mem_wr_req || mem_rd_req) begin
          capture    = 1'b1;
          cnt_next   = CNT_W'(LATENCY - 1);
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_next = DONE;
          load_rd    = (op_q == OP_RD);
        end else begin
          cnt_next = cnt_q - 1'b1;
        end
      end
      DONE: begin
        commit_wr  = (op_q == OP_WR);
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // A simultaneous read/write accepts the write; the read stays pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt_q     <= '0;
      op_q      <= OP_RD;
      idx_q     <= '0;
      wr_line_q <= '0;
      rd_line_q <= '0;
    end else begin
      state <= state_next;
      cnt_q <= cnt_next;
      if (capture) begin
        op_q      <= mem_wr_req ? OP_WR : OP_RD;
        idx_q     <= req_idx;
        wr_line_q <= mem_wr_data;
      end
      if (load_rd) begin
        rd_line_q <= arr_rd_line;
      end
    end
  end

  line_mem_array #(
    .LINE_W (CACHE_LINE_WIDTH),
    .DEPTH  (MEM_DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .we      (commit_wr),
    .idx     (idx_q),
    .wr_line (wr_line_q),
    .rd_line (arr_rd_line)
  );

  assign mem_rd_data = rd_line_q;
  assign mem_ready   = (state == DONE);
  assign mem_busy    = (state != IDLE);

endmodule

// File: tb/tb_line_mem_responder.sv
// Bench for line_mem_responder: directed cases from the test plan, then random
// traffic, all compared every cycle against a transaction-level model.
module tb_line_mem_responder;

  localparam int LW    = 128;
  localparam int AW    = 32;
  localparam int DEPTH = 256;
  localparam int LAT   = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          mem_rd_req = 1'b0;
  logic          mem_wr_req = 1'b0;
  logic [AW-1:0] mem_addr = '0;
  logic [LW-1:0] mem_wr_data = '0;
  logic [LW-1:0] mem_rd_data;
  logic          mem_ready;
  logic          mem_busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  line_mem_responder #(
    .CACHE_LINE_WIDTH (LW),
    .ADDR_WIDTH       (AW),
    .DATA_WIDTH       (32),
    .BLOCK_SIZE       (4),
    .MEM_DEPTH        (DEPTH),
    .LATENCY          (LAT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_rd_req  (mem_rd_req),
    .mem_wr_req  (mem_wr_req),
    .mem_addr    (mem_addr),
    .mem_wr_data (mem_wr_data),
    .mem_rd_data (mem_rd_data),
    .mem_ready   (mem_ready),
    .mem_busy    (mem_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transaction-level model: an accepted access occupies cycles acc+1..acc+LAT+1
  // and completes in the last of them; memory is a plain array of lines.
  logic [LW-1:0] m_mem [DEPTH];
  logic [LW-1:0] m_rd_line = '0;
  logic [LW-1:0] m_data    = '0;
  bit            m_valid   = 1'b0;
  bit            m_active  = 1'b0;
  bit            m_wr      = 1'b0;
  bit            done_now  = 1'b0;
  int            m_acc     = 0;
  int            m_idx     = 0;

  always @(negedge clk) begin
    done_now = 1'b0;
    if (m_valid) begin
      done_now = m_active && (cyc == m_acc + LAT + 1);
      if (done_now && !m_wr) m_rd_line = m_mem[m_idx];
      check("model_ready", LW'(mem_ready), LW'(done_now));
      check("model_busy", LW'(mem_busy), LW'(m_active));
      check("model_rd_data", mem_rd_data, m_rd_line);
    end
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      m_active  = 1'b0;
      m_rd_line = '0;
      m_valid   = 1'b1;
    end else if (m_valid) begin
      if (done_now) begin
        if (m_wr) m_mem[m_idx] = m_data;
        m_active = 1'b0;
      end else if (!m_active && (mem_wr_req || mem_rd_req)) begin
        m_active = 1'b1;
        m_acc    = cyc;
        m_wr     = mem_wr_req;
        m_idx    = int'((mem_addr >> 2) % 32'(DEPTH));
        m_data   = mem_wr_data;
      end
    end
  end

  task automatic wait_ready(input int t0, output int lat);
    lat = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (mem_ready) begin
        lat = cyc - t0;
        break;
      end
    end
    if (lat < 0) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got no mem_ready expected one within 100 cycles (start %0d)", t0);
    end
  endtask

  // Issues a request in a fresh cycle; drops it (or, for rd+wr, only the write)
  // in the mem_ready cycle. lat2/rdata cover the trailing read of a rd+wr pair.
  task automatic do_req(input bit wr, input bit rd, input logic [AW-1:0] addr,
                        input logic [LW-1:0] data, input int drop_at,
                        output int lat1, output int lat2, output logic [LW-1:0] rdata);
    int t0;
    @(posedge clk); #1;
    t0 = cyc;
    mem_wr_req = wr; mem_rd_req = rd; mem_addr = addr; mem_wr_data = data;
    if (drop_at > 0) begin
      repeat (drop_at) @(posedge clk);
      #1; mem_wr_req = 1'b0; mem_rd_req = 1'b0;
    end
    wait_ready(t0, lat1);
    rdata = mem_rd_data;
    lat2 = 0;
    #1;
    mem_wr_req = 1'b0;
    if (wr && rd) begin
      wait_ready(t0, lat2);
      rdata = mem_rd_data;
      #1;
    end
    mem_rd_req = 1'b0;
  endtask

  logic [LW-1:0] rdata;
  int lat1, lat2, t0, pulses;
  localparam logic [LW-1:0] LINE_A = 128'h44443333_22221111_DEADBEEF_CAFEF00D;
  localparam logic [LW-1:0] LINE_B = 128'h01234567_89ABCDEF_00112233_445566A5;
  localparam logic [LW-1:0] LINE_C = 128'h0BADC0DE_13579BDF_2468ACE0_FEEDFACE;
  localparam logic [LW-1:0] LINE_D = 128'h55555555_AAAAAAAA_12121212_34343434;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_ready", LW'(mem_ready), '0);
    check("reset_busy", LW'(mem_busy), '0);
    check("reset_rd_data", mem_rd_data, '0);

    do_req(1'b0, 1'b1, 32'h10, '0, 0, lat1, lat2, rdata);
    check("read_after_reset_latency", LW'(lat1), LW'(5));
    check("read_after_reset_data", rdata, '0);

    do_req(1'b1, 1'b0, 32'h20, LINE_A, 0, lat1, lat2, rdata);
    check("write_latency", LW'(lat1), LW'(5));
    do_req(1'b0, 1'b1, 32'h23, '0, 0, lat1, lat2, rdata);
    check("raw_word_offset_data", rdata, LINE_A);

    do_req(1'b1, 1'b1, 32'h40, LINE_B, 0, lat1, lat2, rdata);
    check("rdwr_write_first_latency", LW'(lat1), LW'(5));
    check("rdwr_read_latency", LW'(lat2), LW'(11));
    check("rdwr_read_data", rdata, LINE_B);

    do_req(1'b1, 1'b0, 32'h408, LINE_C, 0, lat1, lat2, rdata);
    do_req(1'b0, 1'b1, 32'h8, '0, 0, lat1, lat2, rdata);
    check("wrap_data", rdata, LINE_C);

    // Read dropped mid-wait, then a new read raised during its DONE cycle.
    @(posedge clk); #1;
    t0 = cyc; mem_rd_req = 1'b1; mem_addr = 32'h20;
    repeat (2) @(posedge clk);
    #1 mem_rd_req = 1'b0;
    wait_ready(t0, lat1);
    check("dropped_read_latency", LW'(lat1), LW'(5));
    check("dropped_read_data", mem_rd_data, LINE_A);
    #1 mem_rd_req = 1'b1; mem_addr = 32'h408;
    wait_ready(t0, lat2);
    check("done_cycle_request_latency", LW'(lat2), LW'(11));
    check("done_cycle_request_data", mem_rd_data, LINE_C);
    #1 mem_rd_req = 1'b0;

    // Reset during the wait of a write: no completion, nothing committed.
    @(posedge clk); #1;
    mem_wr_req = 1'b1; mem_addr = 32'h50; mem_wr_data = LINE_D;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1; mem_wr_req = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    pulses = 0;
    repeat (10) begin
      @(negedge clk);
      if (mem_ready) pulses++;
    end
    check("aborted_write_pulses", LW'(pulses), '0);
    do_req(1'b0, 1'b1, 32'h50, '0, 0, lat1, lat2, rdata);
    check("aborted_write_data", rdata, '0);

    for (int n = 0; n < 200; n++) begin
      int kind;
      logic [AW-1:0] addr;
      logic [LW-1:0] data;
      kind = int'($urandom_range(0, 9));
      addr = 32'($urandom_range(0, 63)) + (($urandom_range(0, 1) == 1) ? 32'(DEPTH * 4) : 32'h0);
      data = {$urandom(), $urandom(), $urandom(), $urandom()};
      repeat ($urandom_range(0, 2)) @(posedge clk);
      if ($urandom_range(0, 24) == 0) begin
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
      end
      if (kind <= 3) begin
        do_req(1'b1, 1'b0, addr, data, 0, lat1, lat2, rdata);
        check("rand_write_latency", LW'(lat1), LW'(LAT + 1));
      end else if (kind <= 7) begin
        do_req(1'b0, 1'b1, addr, data, 0, lat1, lat2, rdata);
        check("rand_read_latency", LW'(lat1), LW'(LAT + 1));
      end else if (kind == 8) begin
        do_req(1'b1, 1'b1, addr, data, 0, lat1, lat2, rdata);
        check("rand_rdwr_latency", LW'(lat2), LW'(2 * LAT + 3));
        check("rand_rdwr_data", rdata, data);
      end else begin
        do_req(1'b0, 1'b1, addr, data, int'($urandom_range(1, 3)), lat1, lat2, rdata);
        check("rand_dropped_latency", LW'(lat1), LW'(LAT + 1));
      end
    end

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test expected finish before 500000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
